// File: rtl/awgn_pkg.sv
// ============================================================================
// Module      : awgn_pkg
// Description : Shared Tausworthe constants and state-controller FSM encoding
//               for the AWGN generator URNG front end.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package awgn_pkg;

    // Per-component masks clearing the low bits that never feed the recurrence
    localparam logic [31:0] c_taus_mask1 = 32'hFFFF_FFFE;
    localparam logic [31:0] c_taus_mask2 = 32'hFFFF_FFF8;
    localparam logic [31:0] c_taus_mask3 = 32'hFFFF_FFF0;

    // Shift triplets (inner-left, right, mask-left) per component
    localparam int c_taus1_a = 13;
    localparam int c_taus1_b = 19;
    localparam int c_taus1_c = 12;
    localparam int c_taus2_a = 2;
    localparam int c_taus2_b = 25;
    localparam int c_taus2_c = 4;
    localparam int c_taus3_a = 3;
    localparam int c_taus3_b = 11;
    localparam int c_taus3_c = 17;

    // Smallest seeds that keep each component out of its degenerate subspace
    localparam logic [31:0] c_seed1_min = 32'd2;
    localparam logic [31:0] c_seed2_min = 32'd8;
    localparam logic [31:0] c_seed3_min = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } taus_state_t;

endpackage

`default_nettype wire

// File: rtl/taus_next.sv
// ============================================================================
// Module      : taus_next
// Description : Combinational next-state function of the three Tausworthe
//               component generators.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module taus_next
    import awgn_pkg::*;
(
    input  logic [31:0] s1,
    input  logic [31:0] s2,
    input  logic [31:0] s3,
    output logic [31:0] n1,
    output logic [31:0] n2,
    output logic [31:0] n3
);

    always_comb begin
        n1 = ((s1 & c_taus_mask1) << c_taus1_c) ^ (((s1 << c_taus1_a) ^ s1) >> c_taus1_b);
        n2 = ((s2 & c_taus_mask2) << c_taus2_c) ^ (((s2 << c_taus2_a) ^ s2) >> c_taus2_b);
        n3 = ((s3 & c_taus_mask3) << c_taus3_c) ^ (((s3 << c_taus3_a) ^ s3) >> c_taus3_b);
    end

endmodule

`default_nettype wire

// File: rtl/taus_state_ctrl.sv
// ============================================================================
// Module      : taus_state_ctrl
// Description : Seed load/sanitise, warm-up and handshake-driven advance of
//               the three Tausworthe states feeding the URNG combiner.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module taus_state_ctrl
    import awgn_pkg::*;
#(
    parameter int          WARMUP_CYCLES = 16,
    parameter logic [31:0] DEF_SEED1     = 32'h0000_1234,
    parameter logic [31:0] DEF_SEED2     = 32'h0000_5678,
    parameter logic [31:0] DEF_SEED3     = 32'h0009_ABCD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_load,
    input  logic [31:0] seed_in1,
    input  logic [31:0] seed_in2,
    input  logic [31:0] seed_in3,
    input  logic        adv_ready,
    output logic [31:0] urng_seed1,
    output logic [31:0] urng_seed2,
    output logic [31:0] urng_seed3,
    output logic        seed_valid,
    output logic        warming,
    output logic        seed_err
);

    localparam int CNT_W        = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam int CNT_LAST_INT = (WARMUP_CYCLES > 0) ? (WARMUP_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_INT);

    taus_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;

    logic        w_bad1;
    logic        w_bad2;
    logic        w_bad3;
    logic [31:0] w_san1;
    logic [31:0] w_san2;
    logic [31:0] w_san3;
    logic [31:0] w_n1;
    logic [31:0] w_n2;
    logic [31:0] w_n3;

    always_comb begin
        w_bad1 = (seed_in1 < c_seed1_min);
        w_bad2 = (seed_in2 < c_seed2_min);
        w_bad3 = (seed_in3 < c_seed3_min);
        w_san1 = w_bad1 ? DEF_SEED1 : seed_in1;
        w_san2 = w_bad2 ? DEF_SEED2 : seed_in2;
        w_san3 = w_bad3 ? DEF_SEED3 : seed_in3;
    end

    taus_next u_next (
        .s1 (urng_seed1),
        .s2 (urng_seed2),
        .s3 (urng_seed3),
        .n1 (w_n1),
        .n2 (w_n2),
        .n3 (w_n3)
    );

    // A seed load overrides every state, including a concurrent RUN advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            urng_seed1 <= '0;
            urng_seed2 <= '0;
            urng_seed3 <= '0;
            seed_valid <= 1'b0;
            warming    <= 1'b0;
            seed_err   <= 1'b0;
        end else if (seed_load) begin
            urng_seed1 <= w_san1;
            urng_seed2 <= w_san2;
            urng_seed3 <= w_san3;
            r_cnt      <= '0;
            if (w_bad1 || w_bad2 || w_bad3) begin
                seed_err <= 1'b1;
            end
            if (WARMUP_CYCLES == 0) begin
                r_state    <= ST_RUN;
                seed_valid <= 1'b1;
                warming    <= 1'b0;
            end else begin
                r_state    <= ST_WARMUP;
                seed_valid <= 1'b0;
                warming    <= 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    seed_valid <= 1'b0;
                    warming    <= 1'b0;
                end
                ST_WARMUP: begin
                    urng_seed1 <= w_n1;
                    urng_seed2 <= w_n2;
                    urng_seed3 <= w_n3;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state    <= ST_RUN;
                        seed_valid <= 1'b1;
                        warming    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (adv_ready) begin
                        urng_seed1 <= w_n1;
                        urng_seed2 <= w_n2;
                        urng_seed3 <= w_n3;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    seed_valid <= 1'b0;
                    warming    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_taus_state_ctrl.sv
// ============================================================================
// Module      : tb_taus_state_ctrl
// Description : Directed self-checking bench for taus_state_ctrl, with one
//               zero-warm-up instance and one 16-cycle warm-up instance.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_taus_state_ctrl;

    logic        clk;
    logic        reset;
    logic        adv_ready;
    logic [31:0] seed_in1, seed_in2, seed_in3;
    logic        seed_load0, seed_load16;

    logic [31:0] a1, a2, a3;
    logic        a_valid, a_warm, a_err;
    logic [31:0] b1, b2, b3;
    logic        b_valid, b_warm, b_err;

    int passed = 0;
    int total  = 0;

    taus_state_ctrl #(.WARMUP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .seed_load(seed_load0),
        .seed_in1(seed_in1), .seed_in2(seed_in2), .seed_in3(seed_in3),
        .adv_ready(adv_ready),
        .urng_seed1(a1), .urng_seed2(a2), .urng_seed3(a3),
        .seed_valid(a_valid), .warming(a_warm), .seed_err(a_err)
    );

    taus_state_ctrl #(.WARMUP_CYCLES(16)) dut16 (
        .clk(clk), .reset(reset), .seed_load(seed_load16),
        .seed_in1(seed_in1), .seed_in2(seed_in2), .seed_in3(seed_in3),
        .adv_ready(adv_ready),
        .urng_seed1(b1), .urng_seed2(b2), .urng_seed3(b3),
        .seed_valid(b_valid), .warming(b_warm), .seed_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden next-state written straight from the recurrence definitions
    function automatic logic [95:0] model_next(input logic [95:0] s);
        logic [31:0] x1, x2, x3;
        x1 = s[95:64]; x2 = s[63:32]; x3 = s[31:0];
        x1 = ((x1 & 32'hFFFFFFFE) << 12) ^ (((x1 << 13) ^ x1) >> 19);
        x2 = ((x2 & 32'hFFFFFFF8) << 4)  ^ (((x2 << 2)  ^ x2) >> 25);
        x3 = ((x3 & 32'hFFFFFFF0) << 17) ^ (((x3 << 3)  ^ x3) >> 11);
        return {x1, x2, x3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if ({a1, a2, a3, a_valid, a_warm, a_err} !== 99'd0)
            $display("FAIL reset_w0: got %h %h %h v%b w%b e%b, want all zero", a1, a2, a3, a_valid, a_warm, a_err);
        else passed++;
        tick(); tick();
        total++;
        if ({b1, b2, b3, b_valid, b_warm, b_err} !== 99'd0)
            $display("FAIL reset_w16: got %h %h %h v%b w%b e%b, want all zero", b1, b2, b3, b_valid, b_warm, b_err);
        else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero_warmup();
        seed_in1 = 32'd2; seed_in2 = 32'd8; seed_in3 = 32'd16;
        seed_load0 = 1'b1;
        tick();
        seed_load0 = 1'b0;
        total++;
        if ({a1, a2, a3} !== {32'd2, 32'd8, 32'd16})
            $display("FAIL w0_load: got %h %h %h, want 2 8 16", a1, a2, a3);
        else passed++;
        total++;
        if ({a_valid, a_warm, a_err} !== 3'b100)
            $display("FAIL w0_flags: got v%b w%b e%b, want v1 w0 e0", a_valid, a_warm, a_err);
        else passed++;
        adv_ready = 1'b1;
        tick();
        adv_ready = 1'b0;
        total++;
        if ({a1, a2, a3} !== {32'h00002000, 32'h00000080, 32'h00200000})
            $display("FAIL w0_adv: got %h %h %h, want 00002000 00000080 00200000", a1, a2, a3);
        else passed++;
        tick();
        total++;
        if ({a1, a2, a3} !== {32'h00002000, 32'h00000080, 32'h00200000})
            $display("FAIL w0_hold: got %h %h %h, want 00002000 00000080 00200000", a1, a2, a3);
        else passed++;
    endtask

    task automatic test_sanitise();
        seed_in1 = 32'd1; seed_in2 = 32'd7; seed_in3 = 32'd15;
        seed_load0 = 1'b1;
        tick();
        seed_load0 = 1'b0;
        total++;
        if ({a1, a2, a3} !== {32'h1234, 32'h5678, 32'h9ABCD})
            $display("FAIL san_default: got %h %h %h, want 1234 5678 9abcd", a1, a2, a3);
        else passed++;
        total++;
        if (a_err !== 1'b1)
            $display("FAIL san_err_set: got %b, want 1", a_err);
        else passed++;
        seed_in1 = 32'd2; seed_in2 = 32'd8; seed_in3 = 32'd16;
        seed_load0 = 1'b1;
        tick();
        seed_load0 = 1'b0;
        total++;
        if ({a1, a2, a3} !== {32'd2, 32'd8, 32'd16})
            $display("FAIL san_legal: got %h %h %h, want 2 8 16", a1, a2, a3);
        else passed++;
        total++;
        if (a_err !== 1'b1)
            $display("FAIL san_err_sticky: got %b, want 1", a_err);
        else passed++;
    endtask

    task automatic test_warmup(output logic [95:0] m);
        seed_in1 = 32'hDEADBEEF; seed_in2 = 32'h12345678; seed_in3 = 32'hCAFEF00D;
        adv_ready = 1'b0;
        seed_load16 = 1'b1;
        tick();
        seed_load16 = 1'b0;
        m = {32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D};
        total++;
        if ({b1, b2, b3, b_valid, b_warm} !== {m, 1'b0, 1'b1})
            $display("FAIL wu_load: got %h %h %h v%b w%b, want %h v0 w1", b1, b2, b3, b_valid, b_warm, m);
        else passed++;
        for (int k = 1; k <= 16; k++) begin
            tick();
            m = model_next(m);
            total++;
            if ({b1, b2, b3} !== m)
                $display("FAIL wu_state[%0d]: got %h %h %h, want %h", k, b1, b2, b3, m);
            else passed++;
            total++;
            if ({b_warm, b_valid} !== {(k < 16), (k == 16)})
                $display("FAIL wu_flags[%0d]: got w%b v%b, want w%b v%b", k, b_warm, b_valid, (k < 16), (k == 16));
            else passed++;
        end
        total++;
        if (b_err !== 1'b0)
            $display("FAIL wu_err: got %b, want 0", b_err);
        else passed++;
    endtask

    task automatic test_random_run(input logic [95:0] start);
        logic [95:0] m;
        logic        r;
        m = start;
        for (int i = 0; i < 1000; i++) begin
            r = 1'($urandom_range(0, 1));
            adv_ready = r;
            tick();
            if (r) m = model_next(m);
            total++;
            if ({b1, b2, b3, b_valid} !== {m, 1'b1})
                $display("FAIL run[%0d]: got %h %h %h v%b, want %h v1", i, b1, b2, b3, b_valid, m);
            else passed++;
        end
        adv_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        seed_in1 = 32'd0; seed_in2 = 32'd100; seed_in3 = 32'd5;
        seed_load16 = 1'b1;
        adv_ready = 1'b1;
        tick();
        seed_load16 = 1'b0;
        adv_ready = 1'b0;
        total++;
        if ({b1, b2, b3} !== {32'h1234, 32'd100, 32'h9ABCD})
            $display("FAIL collide_state: got %h %h %h, want 1234 64 9abcd", b1, b2, b3);
        else passed++;
        total++;
        if ({b_valid, b_warm, b_err} !== 3'b011)
            $display("FAIL collide_flags: got v%b w%b e%b, want v0 w1 e1", b_valid, b_warm, b_err);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        adv_ready = 1'b1;
        tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({a1, a2, a3, a_valid, a_warm, a_err} !== 99'd0)
            $display("FAIL async_reset_run: got %h %h %h v%b w%b e%b, want all zero", a1, a2, a3, a_valid, a_warm, a_err);
        else passed++;
        total++;
        if ({b1, b2, b3, b_valid, b_warm, b_err} !== 99'd0)
            $display("FAIL async_reset_warm: got %h %h %h v%b w%b e%b, want all zero", b1, b2, b3, b_valid, b_warm, b_err);
        else passed++;
        tick();
        reset = 1'b0;
        tick(); tick();
        total++;
        if ({a1, a2, a3, a_valid} !== 97'd0)
            $display("FAIL idle_after_reset: got %h %h %h v%b, want all zero", a1, a2, a3, a_valid);
        else passed++;
        adv_ready = 1'b0;
    endtask

    initial begin
        logic [95:0] m;
        reset = 1'b1; adv_ready = 1'b0;
        seed_load0 = 1'b0; seed_load16 = 1'b0;
        seed_in1 = '0; seed_in2 = '0; seed_in3 = '0;
        test_reset();
        test_zero_warmup();
        test_sanitise();
        test_warmup(m);
        test_random_run(m);
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
